// File: rtl/sevseg_pkg.sv
// rtl/sevseg_pkg.sv - shared widths and the active-low seven-segment lookup table
package sevseg_pkg;

    localparam int SEG_W    = 7;
    localparam int NIBBLE_W = 4;

    // Segment order is {a,b,c,d,e,f,g}; a 0 lights the segment.
    localparam logic [SEG_W-1:0] SEG_0 = 7'b0000001;
    localparam logic [SEG_W-1:0] SEG_1 = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_2 = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_3 = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_4 = 7'b1001100;
    localparam logic [SEG_W-1:0] SEG_5 = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_6 = 7'b0100000;
    localparam logic [SEG_W-1:0] SEG_7 = 7'b0001111;
    localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9 = 7'b0001100;
    localparam logic [SEG_W-1:0] SEG_A = 7'b0001000;
    localparam logic [SEG_W-1:0] SEG_B = 7'b1100000;
    localparam logic [SEG_W-1:0] SEG_C = 7'b0110001;
    localparam logic [SEG_W-1:0] SEG_D = 7'b1000010;
    localparam logic [SEG_W-1:0] SEG_E = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_F = 7'b0111000;

    localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/sevseg_decoder.sv
// rtl/sevseg_decoder.sv - combinational hex nibble to active-low abcdefg lookup
module sevseg_decoder
    import sevseg_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble,
    output logic [SEG_W-1:0]    seg
);

    always_comb begin
        seg = SEG_OFF;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/sevseg_scan_mux.sv
// rtl/sevseg_scan_mux.sv - multi-digit seven-segment scan driver with PWM brightness and blanking
// Optional leading-zero suppression: define SEVSEG_LEADING_ZERO_BLANK_EN.
module sevseg_scan_mux
    import sevseg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE_W = 17,
    parameter int BRIGHT_W   = 3
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]          dp,
    input  logic [NUM_DIGITS-1:0]          blank,
    input  logic [BRIGHT_W-1:0]            brightness,
    output logic [NUM_DIGITS-1:0]          an,
    output logic [7:0]                     pattern
);

    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [7:0]            pattern_q, pattern_d;

    logic [NIBBLE_W-1:0]   sel_nibble;
    logic [SEG_W-1:0]      sel_seg;
    logic [BRIGHT_W-1:0]   phase;
    logic [NUM_DIGITS-1:0] lz_sup;
    logic                  slot_tick;
    logic                  lit;

`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    logic lz_run;

    // Suppression propagates down from the top digit while nibbles stay zero; digit 0 always shows.
    always_comb begin
        lz_sup = '0;
        lz_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lz_run    = lz_run && (digits[NIBBLE_W*i +: NIBBLE_W] == 4'h0);
            lz_sup[i] = lz_run;
        end
    end
`else
    assign lz_sup = '0;
`endif

    assign sel_nibble = digits[NIBBLE_W*idx_q +: NIBBLE_W];
    assign phase      = presc_q[PRESCALE_W-1 -: BRIGHT_W];
    assign slot_tick  = (presc_q == '1);

    sevseg_decoder u_decoder (
        .nibble (sel_nibble),
        .seg    (sel_seg)
    );

    always_comb begin
        presc_d   = presc_q + PRESCALE_W'(1);
        idx_d     = idx_q;
        an_d      = '1;
        pattern_d = 8'hFF;

        if (slot_tick) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end

        // The first cycle of each slot stays dark so the previous digit never ghosts onto the new anode.
        lit = (presc_q != '0) && (phase < brightness) && !blank[idx_q] && !lz_sup[idx_q];

        if (lit) begin
            an_d[idx_q] = 1'b0;
            pattern_d   = {~dp[idx_q], sel_seg};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q   <= '0;
            idx_q     <= '0;
            an_q      <= '1;
            pattern_q <= 8'hFF;
        end else begin
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            pattern_q <= pattern_d;
        end
    end

    assign an      = an_q;
    assign pattern = pattern_q;

endmodule

// File: tb/tb_sevseg_scan_mux.sv
// tb/tb_sevseg_scan_mux.sv - scoreboard bench for sevseg_scan_mux at 4 and 3 digits
`timescale 1ns/1ps
module tb_sevseg_scan_mux;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  blank = '0;
    logic [1:0]  brightness = '0;
    logic [3:0]  an4;
    logic [7:0]  pat4;
    logic [2:0]  an3;
    logic [7:0]  pat3;

    int n_checks = 0;
    int n_fail   = 0;
    int t        = 0;

    logic [23:0] sb [$];

    logic [6:0] seg_ref [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    always #5 clk = ~clk;

    sevseg_scan_mux #(.NUM_DIGITS(4), .PRESCALE_W(4), .BRIGHT_W(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .digits     (digits),
        .dp         (dp),
        .blank      (blank),
        .brightness (brightness),
        .an         (an4),
        .pattern    (pat4)
    );

    sevseg_scan_mux #(.NUM_DIGITS(3), .PRESCALE_W(4), .BRIGHT_W(2)) dut3 (
        .clk        (clk),
        .reset_n    (reset_n),
        .digits     (digits[11:0]),
        .dp         (dp[2:0]),
        .blank      (blank[2:0]),
        .brightness (brightness),
        .an         (an3),
        .pattern    (pat3)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    // Reference: slot = t/16, prescaler = t%16, phase = prescaler/4; returns {an[3:0], pattern}.
    function automatic logic [11:0] model(input int n, input int tt);
        int   ps;
        int   ix;
        logic on;
        logic sup;
        logic [3:0] a;
        logic [7:0] p;
        ps  = tt % 16;
        ix  = (tt / 16) % n;
        a   = 4'hF;
        p   = 8'hFF;
        sup = 1'b0;
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
        if (ix != 0) begin
            sup = 1'b1;
            for (int j = ix; j < n; j++)
                if (digits[4*j +: 4] != 4'h0) sup = 1'b0;
        end
`endif
        on = (ps != 0) && ((ps / 4) < int'(brightness)) && !blank[ix] && !sup;
        if (on) begin
            a[ix] = 1'b0;
            p     = {~dp[ix], seg_ref[digits[4*ix +: 4]]};
        end
        return {a, p};
    endfunction

    task automatic tick();
        logic [11:0] e4;
        logic [11:0] e3;
        logic [23:0] e;
        if (!reset_n) begin
            e4 = 12'hFFF;
            e3 = 12'hFFF;
            t  = 0;
        end else begin
            e4 = model(4, t);
            e3 = model(3, t);
            t++;
        end
        sb.push_back({e4, e3});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_eq("an4", 32'(an4), 32'(e[23:20]));
        check_eq("pattern4", 32'(pat4), 32'(e[19:12]));
        check_eq("an3", 32'(an3), 32'(e[10:8]));
        check_eq("pattern3", 32'(pat3), 32'(e[7:0]));
        check_eq("an4_single_low", 32'($countones(~an4) <= 1), 32'd1);
        check_eq("an3_single_low", 32'($countones(~an3) <= 1), 32'd1);
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    initial begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            digits     = 16'($urandom);
            dp         = 4'($urandom);
            blank      = 4'($urandom);
            brightness = 2'($urandom);
            tick();
        end

        digits = 16'h1234; dp = 4'h0; blank = 4'h0; brightness = 2'd3;
        reset_n = 1'b1;
        run(80);

        brightness = 2'd1;
        run(64);
        brightness = 2'd0;
        run(64);

        brightness = 2'd3; blank = 4'b0100; dp = 4'b0001; digits = 16'hFFFF;
        run(64);

        for (int i = 0; i < 120; i++) begin
            digits     = 16'($urandom);
            dp         = 4'($urandom);
            blank      = 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
            brightness = 2'($urandom);
            tick();
        end

        // Asynchronous reset in the middle of a lit slot.
        digits = 16'h89AB; dp = 4'hF; blank = 4'h0; brightness = 2'd3;
        while ((t % 16) != 7) tick();
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_an4", 32'(an4), 32'hF);
        check_eq("async_pattern4", 32'(pat4), 32'hFF);
        check_eq("async_an3", 32'(an3), 32'h7);
        run(3);
        reset_n = 1'b1;
        run(70);

        digits = 16'h0050; dp = 4'h0;
        run(64);
        digits = 16'h0000;
        run(64);
        digits = 16'hC0DE;
        run(64);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sevseg_scan_mux.md
Name: sevseg_scan_mux

Overview:
Parametrised multi-digit seven-segment scan driver. It is the next generation of the 4-digit display mux on the FPGA board.
- Time-multiplexes NUM_DIGITS hex digits onto shared, active-low segment/dp pins.
- Adds PWM brightness control, per-digit blanking and registered, glitch-free outputs.
- Sits between the debug/register-display logic (e.g. the core's reg_debug_output) and the board's an/segment pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..16)
PRESCALE_W, 17, width of the refresh prescaler; one digit slot lasts 2^PRESCALE_W clk cycles
BRIGHT_W, 3, width of the brightness control; must be <= PRESCALE_W

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
digits  input  4*NUM_DIGITS  hex nibbles; digit i = digits[4*i+3:4*i], digit 0 rightmost
dp  input  NUM_DIGITS  decimal point per digit, active high
blank  input  NUM_DIGITS  1 = digit i forced dark
brightness  input  BRIGHT_W  on-time control; 0 = display off
an  output  NUM_DIGITS  digit anodes, active low, registered
pattern  output  8  {dp, a,b,c,d,e,f,g}, all active low, registered

Behaviour:
- Reset (reset_n low, asynchronous): prescaler = 0, digit index = 0, an = all 1s, pattern = 8'hFF. State is held while reset_n is low; release is sampled on clk.
- Prescaler: free-running PRESCALE_W-bit counter, +1 per clk, wraps from all-1s to 0.
- Slot tick: asserted in the cycle where prescaler == all-1s. On tick, the digit index advances by 1; it wraps from NUM_DIGITS-1 to 0, and non-power-of-2 NUM_DIGITS is legal.
- PWM: let phase = prescaler[PRESCALE_W-1 -: BRIGHT_W]. The digit is lit iff phase < brightness and blank[idx] == 0.
  - brightness = 0: never lit.
  - brightness = 2^BRIGHT_W-1: lit for (2^B-1)/2^B of each slot.
- Output registration (1 clk latency from index/prescaler/inputs): next an = all 1s with bit idx cleared if lit, otherwise all 1s.
  - Next pattern = {~dp[idx], decode(digits nibble idx)} if lit, otherwise 8'hFF.
  - Exactly one an bit may be low in any cycle; never two.
- Anti-ghosting: the registered outputs are forced dark in the first cycle of every slot (prescaler == 0). This covers every brightness value.
- Inputs are sampled every cycle. A change to digits, dp, blank or brightness appears on the outputs one cycle later; there is no requirement to hold inputs stable within a slot.
- Decode, active low, abcdefg:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0001100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Reset asserted mid-slot: outputs go dark immediately (asynchronously); after release, scanning restarts at digit 0 with a full slot.

Optional Feature:
Macro SEVSEG_LEADING_ZERO_BLANK_EN.
- Defined: a digit is also treated as blanked when its nibble is 0 and every higher-index digit is 0 (or itself blanked by this rule). Digit 0 is never suppressed, so value 0 shows a single "0". The dp of a suppressed digit is also dark.
- Undefined: all digits show, including leading zeros; the logic is absent.

Decomposition:
- Package sevseg_pkg:
  - SEG_W = 7, NIBBLE_W = 4.
  - The 16-entry active-low segment constant table (SEG_0..SEG_F).
  - SEG_OFF = 7'h7F.
- Sub-module sevseg_decoder: purely combinational 4-bit to 7-bit lookup using the package table. It is instantiated once, on the selected nibble.
- Everything else (prescaler, index, PWM compare, output registers, leading-zero logic) stays in sevseg_scan_mux.

Test Plan:
- Bench parameters throughout: PRESCALE_W=4, BRIGHT_W=2, NUM_DIGITS=4.
- Reset: hold reset_n low 5 cycles with random inputs -> an=4'b1111, pattern=8'hFF every cycle; after release, first lit digit is index 0.
- Scan order: digits=16'h1234, dp=0, blank=0, brightness=3 -> an cycles 1110,1101,1011,0111 every 16 clks; patterns 1 -> 8'hCF, 2 -> 8'h92, 3 -> 8'h86, 4 -> 8'hCC; no cycle has two an bits low.
- PWM: brightness=1 -> each digit lit for prescaler 1..3 only (3 of 16 clks; prescaler 0 dark per anti-ghosting); brightness=0 -> an stays 4'b1111 for 64 clks.
- Blank/dp: blank=4'b0100, dp=4'b0001, digits=16'hFFFF -> digit 2 slot dark; digit 0 pattern = 8'h38 (dp low); others 8'hB8.
- Wrap with NUM_DIGITS=3: index sequence 0,1,2,0 -> an 110,101,011,110.
- SEVSEG_LEADING_ZERO_BLANK_EN: digits=16'h0050 -> digit 3 dark, digit 2 dark, digits 1 and 0 lit ("50"); digits=16'h0000 -> only digit 0 lit showing 8'h81.
